// File: rtl/object_plotter_if.sv
// object_plotter_if
// Groups the request side (game logic -> plotter) and the pixel side
// (plotter -> VGA adapter) of object_plotter into one bundle.
//   startPlot, object, newX/newY, oldX/oldY, sizeX/sizeY : update request
//   x, y, colour, plot                                   : pixel stream
//   busy, done                                           : request status
// master : game-logic side (drives the request, observes stream/status)
// slave  : object_plotter itself
interface object_plotter_if;
  logic       startPlot;
  logic [1:0] object;
  logic [7:0] newX;
  logic [6:0] newY;
  logic [7:0] oldX;
  logic [6:0] oldY;
  logic [7:0] sizeX;
  logic [6:0] sizeY;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/object_plotter.sv
// object_plotter
// Turns one rectangle-update request into a pixel stream for the 160x120
// VGA frame buffer: the old rectangle is erased in BG_COLOUR, then the new
// rectangle is drawn in the object's colour, one pixel per clock, row-major.
// Requests arriving while a stream is in progress are dropped.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : object_plotter_if.slave (request inputs, pixel/status outputs)
// All outputs are registered.
module object_plotter #(
  parameter logic [7:0] MAX_X         = 8'd159,
  parameter logic [6:0] MAX_Y         = 7'd119,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] BALL_COLOUR   = 3'b111,
  parameter logic [2:0] PADDLE_COLOUR = 3'b010,
  parameter logic [2:0] BLOCK_COLOUR  = 3'b100
) (
  input  logic                  clk,
  input  logic                  reset,
  object_plotter_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] ox_q, ox_d, nx_q, nx_d, w_q, w_d;
  logic [6:0] oy_q, oy_d, ny_q, ny_d, h_q, h_d;
  logic [1:0] obj_q, obj_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] px;
  logic [7:0] py;
  logic       last_col, last_row;
  logic [2:0] obj_colour;

  // Pixel address of the current scan position, one bit wider than the
  // frame coordinates so that overflow past the edge clips instead of wrapping.
  always_comb begin
    base_x   = (state_q == ERASE) ? ox_q : nx_q;
    base_y   = (state_q == ERASE) ? oy_q : ny_q;
    px       = {1'b0, base_x} + {1'b0, cx_q};
    py       = {1'b0, base_y} + {1'b0, cy_q};
    last_col = (cx_q == (w_q - 8'd1));
    last_row = (cy_q == (h_q - 7'd1));
    case (obj_q)
      2'b00:   obj_colour = BALL_COLOUR;
      2'b01:   obj_colour = PADDLE_COLOUR;
      2'b10:   obj_colour = BLOCK_COLOUR;
      default: obj_colour = BG_COLOUR;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    w_d      = w_q;
    h_d      = h_q;
    obj_d    = obj_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.startPlot && (bus.object != 2'b11)) begin
          ox_d  = bus.oldX;
          oy_d  = bus.oldY;
          nx_d  = bus.newX;
          ny_d  = bus.newY;
          w_d   = bus.sizeX;
          h_d   = bus.sizeY;
          obj_d = bus.object;
          cx_d  = '0;
          cy_d  = '0;
          // An empty rectangle has nothing to scan: go straight to DONE so
          // that done lands one cycle after accept.
          if ((bus.sizeX == 8'd0) || (bus.sizeY == 7'd0))
            state_d = DONE;
          else if ((bus.oldX == bus.newX) && (bus.oldY == bus.newY))
            state_d = DRAW;
          else
            state_d = ERASE;
        end
      end

      ERASE, DRAW: begin
        busy_d   = 1'b1;
        x_d      = px[7:0];
        y_d      = py[6:0];
        plot_d   = (px <= {1'b0, MAX_X}) && (py <= {1'b0, MAX_Y});
        colour_d = (state_q == ERASE) ? BG_COLOUR : obj_colour;
        if (last_col) begin
          cx_d = '0;
          if (last_row) begin
            cy_d    = '0;
            state_d = (state_q == ERASE) ? DRAW : DONE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      obj_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      w_q      <= w_d;
      h_q      <= h_d;
      obj_q    <= obj_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_object_plotter.sv
// tb_object_plotter
// Directed bench for object_plotter: reset values, erase/draw streams,
// clipping, dropped and ignored requests, mid-stream reset and zero size.
// Cycle N+i means the output values visible just after rising edge N+i,
// where N is the edge that samples startPlot.
module tb_object_plotter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  object_plotter_if bus();

  object_plotter #(
    .MAX_X(8'd159),
    .MAX_Y(7'd119)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and clock it in (edge N); returns just after edge N.
  task automatic start_req(input logic [1:0] obj,
                           input logic [7:0] ox, input logic [6:0] oy,
                           input logic [7:0] nx, input logic [6:0] ny,
                           input logic [7:0] w,  input logic [6:0] h);
    bus.object    = obj;
    bus.oldX      = ox;
    bus.oldY      = oy;
    bus.newX      = nx;
    bus.newY      = ny;
    bus.sizeX     = w;
    bus.sizeY     = h;
    bus.startPlot = 1'b1;
    tick();
    bus.startPlot = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%b plot=%b busy=%b done=%b want all 0",
               bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got plot=%b busy=%b done=%b want 000",
               bus.plot, bus.busy, bus.done);
    end
  endtask

  task automatic test_ball(input string tag);
    logic [7:0] ex [8];
    logic [6:0] ey [8];
    logic [2:0] ec;
    ex = '{8'd10, 8'd11, 8'd10, 8'd11, 8'd11, 8'd12, 8'd11, 8'd12};
    ey = '{7'd20, 7'd20, 7'd21, 7'd21, 7'd21, 7'd21, 7'd22, 7'd22};
    start_req(2'b00, 8'd10, 7'd20, 8'd11, 7'd21, 8'd2, 7'd2);
    for (int i = 1; i <= 8; i++) begin
      tick();
      ec = (i <= 4) ? 3'b000 : 3'b111;
      checks++;
      if ({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour} !==
          {1'b1, 1'b1, 1'b0, ex[i-1], ey[i-1], ec}) begin
        errors++;
        $display("FAIL %s_pix%0d got plot=%b busy=%b done=%b (%0d,%0d) c=%b want 110 (%0d,%0d) c=%b",
                 tag, i, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour,
                 ex[i-1], ey[i-1], ec);
      end
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.plot} !== 3'b110) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b plot=%b want 110",
               tag, bus.done, bus.busy, bus.plot);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.plot} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle got done=%b busy=%b plot=%b want 000",
               tag, bus.done, bus.busy, bus.plot);
    end
  endtask

  task automatic test_paddle();
    logic [7:0] exx;
    logic [2:0] ec;
    int bad = 0;
    start_req(2'b01, 8'd100, 7'd2, 8'd99, 7'd2, 8'd16, 7'd1);
    for (int i = 1; i <= 32; i++) begin
      tick();
      exx = (i <= 16) ? 8'(100 + i - 1) : 8'(99 + i - 17);
      ec  = (i <= 16) ? 3'b000 : 3'b010;
      if ({bus.plot, bus.done, bus.x, bus.y, bus.colour} !==
          {1'b1, 1'b0, exx, 7'd2, ec}) begin
        if (bad == 0)
          $display("FAIL paddle_pix%0d got plot=%b done=%b (%0d,%0d) c=%b want 10 (%0d,2) c=%b",
                   i, bus.plot, bus.done, bus.x, bus.y, bus.colour, exx, ec);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    tick();
    checks++;
    if ({bus.done, bus.plot} !== 2'b10) begin
      errors++;
      $display("FAIL paddle_done_at_33 got done=%b plot=%b want 10", bus.done, bus.plot);
    end
    tick();
  endtask

  task automatic test_clip();
    int xi, yi, plots;
    logic ep;
    int bad = 0;
    plots = 0;
    start_req(2'b10, 8'd158, 7'd118, 8'd158, 7'd118, 8'd4, 7'd4);
    for (int i = 1; i <= 16; i++) begin
      tick();
      xi = 158 + (i - 1) % 4;
      yi = 118 + (i - 1) / 4;
      ep = (xi <= 159) && (yi <= 119);
      if (bus.plot === 1'b1) plots++;
      if ({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour} !==
          {ep, 1'b1, 1'b0, 8'(xi), 7'(yi), 3'b100}) begin
        if (bad == 0)
          $display("FAIL clip_pix%0d got plot=%b busy=%b (%0d,%0d) c=%b want plot=%b (%0d,%0d) c=100",
                   i, bus.plot, bus.busy, bus.x, bus.y, bus.colour, ep, 8'(xi), 7'(yi));
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (plots != 4) begin
      errors++;
      $display("FAIL clip_plot_count got %0d want 4", plots);
    end
    tick();
    checks++;
    if ({bus.done, bus.plot} !== 2'b10) begin
      errors++;
      $display("FAIL clip_done_at_17 got done=%b plot=%b want 10", bus.done, bus.plot);
    end
    tick();
  endtask

  task automatic test_drop();
    int dones = 0;
    int done_cyc = -1;
    start_req(2'b00, 8'd10, 7'd20, 8'd11, 7'd21, 8'd2, 7'd2);
    tick();
    tick();
    start_req(2'b01, 8'd50, 7'd50, 8'd60, 7'd60, 8'd3, 7'd3);
    for (int i = 4; i <= 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = i;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL drop_done_count got %0d want 1", dones);
    end
    checks++;
    if (done_cyc != 9) begin
      errors++;
      $display("FAIL drop_done_cycle got %0d want 9", done_cyc);
    end
  endtask

  task automatic test_ignore();
    start_req(2'b11, 8'd1, 7'd1, 8'd5, 7'd5, 8'd2, 7'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.plot, bus.done} !== 3'b000) begin
        errors++;
        $display("FAIL ignore_none_c%0d got busy=%b plot=%b done=%b want 000",
                 i, bus.busy, bus.plot, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_req(2'b00, 8'd10, 7'd20, 8'd11, 7'd21, 8'd2, 7'd2);
    for (int i = 1; i <= 6; i++) tick();
    checks++;
    if ({bus.plot, bus.colour} !== 4'b1111) begin
      errors++;
      $display("FAIL midrst_in_draw got plot=%b c=%b want 1 111", bus.plot, bus.colour);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour} !== 21'd0) begin
      errors++;
      $display("FAIL midrst_outputs got plot=%b busy=%b done=%b (%0d,%0d) c=%b want all 0",
               bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({bus.plot, bus.busy} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_quiet_c%0d got plot=%b busy=%b want 00", i, bus.plot, bus.busy);
      end
    end
    test_ball("after_rst");
  endtask

  task automatic test_zero();
    start_req(2'b10, 8'd30, 7'd30, 8'd40, 7'd40, 8'd0, 7'd3);
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.plot} !== 3'b110) begin
      errors++;
      $display("FAIL zero_done_at_1 got done=%b busy=%b plot=%b want 110",
               bus.done, bus.busy, bus.plot);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.plot} !== 3'b000) begin
      errors++;
      $display("FAIL zero_idle got done=%b busy=%b plot=%b want 000",
               bus.done, bus.busy, bus.plot);
    end
  endtask

  initial begin
    bus.startPlot = 1'b0;
    bus.object    = 2'b11;
    bus.newX      = '0;
    bus.newY      = '0;
    bus.oldX      = '0;
    bus.oldY      = '0;
    bus.sizeX     = '0;
    bus.sizeY     = '0;
    test_reset();
    test_ball("ball");
    test_paddle();
    test_clip();
    test_drop();
    test_ignore();
    test_reset_mid();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/object_plotter.md
# object_plotter

Consumes one rectangle-update request per `startPlot` from the game-logic stage and turns it into a pixel stream for the VGA adapter: erase the object's old rectangle in background colour, then draw its new rectangle in the object's colour. Sits directly between game logic and the VGA adapter's `x`/`y`/`colour`/`plot` inputs on the 160x120 frame buffer. Requests arriving while a stream is in progress are dropped. Game logic updates only every few million cycles, so back-pressure is not needed.

## Interface
- `MAX_X`, 159: largest valid x coordinate.
- `MAX_Y`, 119: largest valid y coordinate.
- `BG_COLOUR`, 3'b000: erase colour.
- `BALL_COLOUR`, 3'b111: colour for object 2'b00.
- `PADDLE_COLOUR`, 3'b010: colour for object 2'b01.
- `BLOCK_COLOUR`, 3'b100: colour for object 2'b10.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `startPlot` in 1: request strobe, sampled on rising `clk`.
- `object` in 2: 00 ball, 01 paddle, 10 block, 11 none.
- `newX` in 8, `newY` in 7: top-left corner of the new rectangle.
- `oldX` in 8, `oldY` in 7: top-left corner of the old rectangle.
- `sizeX` in 8, `sizeY` in 7: rectangle width and height in pixels; the same values apply to the old and new rectangles.
- `x` out 8, `y` out 7: pixel coordinate to the VGA adapter.
- `colour` out 3: pixel colour.
- `plot` out 1: pixel write enable.
- `busy` out 1: high while a request is being serviced.
- `done` out 1: one-cycle pulse when a request completes.

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- **IDLE**
  - A request is accepted when `startPlot`=1 and `object`≠11.
  - On accept, latch all position, size and object inputs.
  - Next state is ERASE.
  - Exception: if `oldX`==`newX` and `oldY`==`newY`, or if `sizeX`==0 or `sizeY`==0, the erase phase is skipped.
  - `startPlot` with `object`=11 is ignored.
- **ERASE**
  - Row-major scan of the old rectangle: column offset cx inner (0..sizeX-1), row offset cy outer (0..sizeY-1).
  - One pixel per cycle, driven with `colour`=`BG_COLOUR`.
  - After the last pixel, go to DRAW.
- **DRAW**
  - Same scan over the new rectangle, with `colour` selected by the latched object.
  - After the last pixel, go to DONE.
  - If a size is 0, DRAW emits no pixels and goes straight to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
- **Coordinate arithmetic**
  - Pixel x = base X + cx and pixel y = base Y + cy.
  - Compute in 9 and 8 bits respectively.
  - If x>`MAX_X` or y>`MAX_Y`, that cycle is still consumed but `plot`=0. This is clipping; there is no wrap-around.
  - `x`/`y` outputs carry the low 8/7 bits.
- `startPlot` while not in IDLE (including DONE) is dropped. There is no queue.
- Colour for an erase is always `BG_COLOUR`, independent of object.

## Timing
- All outputs are registered.
- After `reset`:
  - `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0.
  - State is IDLE and all scan counters are 0.
- Reset asserted mid-stream aborts at that edge. The next cycle shows all outputs at reset values and no further pixels.
- Request accepted at edge N:
  - First pixel appears on the outputs after edge N+1.
  - Erase pixels occupy cycles N+1 .. N+W·H.
  - Draw pixels occupy cycles N+W·H+1 .. N+2·W·H.
  - `done` is high at cycle N+2·W·H+1.
  - `busy` is high from N+1 through the `done` cycle inclusive.
  - Next request can be accepted at edge N+2·W·H+2.
- When erase is skipped, drawing starts at N+1 and `done` is high at N+W·H+1.
- `plot` is 0 in IDLE and DONE.

## Test plan
- Ball request: `object`=00, old (10,20), new (11,21), size 2x2, `startPlot` at edge N.
  - Cycles N+1..N+4 give `plot`=1 with `colour`=000 at (10,20),(11,20),(10,21),(11,21).
  - Cycles N+5..N+8 give `colour`=111 at (11,21),(12,21),(11,22),(12,22).
  - `done` is high at N+9.
- Paddle request: `object`=01, old (100,2), new (99,2), size 16x1.
  - 16 erase pixels, then 16 draw pixels with `colour`=010.
  - `done` is high 33 cycles after accept.
- Clipping: new (158,118), old equal to new, size 4x4.
  - Erase is skipped.
  - 16 cycles are consumed, with `plot`=1 only for (158,118),(159,118),(158,119),(159,119).
  - `done` is high at N+17.
- Drop and ignore:
  - `startPlot` pulsed at N+3 during a ball request is dropped; exactly one `done` is seen.
  - `startPlot` with `object`=11 in IDLE leaves `busy`=0.
- Reset mid-stream: assert `reset` during a DRAW pixel.
  - Next cycle has `plot`=0, `busy`=0, `done`=0.
  - A new request afterwards completes normally.
- Zero size: `sizeX`=0.
  - Erase is skipped and no pixels are plotted.
  - `done` is high at N+1.
